// File: rtl/ad79x8_pkg.sv
// Shared constants for the AD79x8 serial link: control-word bit positions, frame length
// and FSM state encoding. The responder and the master both import this package.
package ad79x8_pkg;

  localparam int unsigned FRAME_LEN   = 16;
  localparam int unsigned CNT_W       = $clog2(FRAME_LEN + 1);

  localparam int unsigned CTL_WRITE   = 15;
  localparam int unsigned CTL_SEQ     = 14;
  localparam int unsigned CTL_ADD_MSB = 12;
  localparam int unsigned CTL_ADD_LSB = 10;
  localparam int unsigned CTL_PM_MSB  = 9;
  localparam int unsigned CTL_SHADOW  = 7;
  localparam int unsigned CTL_RANGE   = 5;
  localparam int unsigned CTL_CODING  = 4;

  // ctrl_reg stores word[15:4], so register bit = word bit - CTL_REG_LSB
  localparam int unsigned CTL_REG_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_OVERRUN = 2'd2
  } state_e;

  function automatic logic [11:0] format_data(input logic [11:0] sample,
                                              input int unsigned res,
                                              input logic        coding);
    logic [11:0] d;
    d = sample;
    if (res == 8) d[3:0] = 4'b0;
    else if (res == 10) d[1:0] = 2'b0;
    d[11] = d[11] ^ coding;
    return d;
  endfunction

endpackage

// File: rtl/ad79x8_edge_sync.sv
// Multi-flop synchronizer with registered rise/fall pulses; total latency from pin to
// pulse is stages+1 clk.
module ad79x8_edge_sync #(
  parameter int unsigned stages = 2,
  parameter logic        init   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [stages-1:0] sync_q;
  logic              prev_q;

  if (stages < 2) begin : g_bad_stages
    $error("ad79x8_edge_sync: stages must be at least 2");
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {stages{init}};
      prev_q <= init;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[stages-2:0], async_in};
      prev_q <= sync_q[stages-1];
      rise   <= sync_q[stages-1] & ~prev_q;
      fall   <= ~sync_q[stages-1] & prev_q;
    end
  end

  assign level = sync_q[stages-1];

endmodule

// File: rtl/ad79x8_responder.sv
// SPI slave emulating an AD7908/AD7918/AD7928: decodes the 16-bit control word and
// returns {0, channel, data} taken from a parallel sample bus.
//
// state    | meaning
// IDLE     | cs high, dout parked at 0, waiting for cs fall
// SHIFT    | frame active, one bit in and one bit out per sclk fall
// OVERRUN  | 16 bits done, extra sclk falls ignored, dout held 0
module ad79x8_responder
  import ad79x8_pkg::*;
#(
  parameter int unsigned resolution  = 12,
  parameter int unsigned sync_stages = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        sclk,
  input  logic        din,
  output logic        dout,
  output logic        dout_en,
  input  logic [95:0] ch_data,
  output logic [11:0] ctrl_reg,
  output logic        frame_done,
  output logic        frame_error
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] SHIFT   = ST_SHIFT;
  localparam logic [1:0] OVERRUN = ST_OVERRUN;

  localparam int unsigned R_SEQ     = CTL_SEQ - CTL_REG_LSB;
  localparam int unsigned R_SHADOW  = CTL_SHADOW - CTL_REG_LSB;
  localparam int unsigned R_CODING  = CTL_CODING - CTL_REG_LSB;
  localparam int unsigned R_ADD_MSB = CTL_ADD_MSB - CTL_REG_LSB;
  localparam int unsigned R_ADD_LSB = CTL_ADD_LSB - CTL_REG_LSB;

  if (!(resolution == 8 || resolution == 10 || resolution == 12)) begin : g_bad_resolution
    $error("ad79x8_responder: resolution must be 8, 10 or 12");
  end

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic unused_sync;

  ad79x8_edge_sync #(.stages(sync_stages), .init(1'b1)) u_cs_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (cs),
    .level    (cs_lvl),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  ad79x8_edge_sync #(.stages(sync_stages), .init(1'b1)) u_sclk_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (sclk),
    .level    (sclk_lvl),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  assign unused_sync = &{1'b0, cs_lvl, sclk_lvl, sclk_rise};

  // din gets the same depth as cs/sclk so it lines up with the fall pulse
  logic [sync_stages-1:0] din_q;
  logic                   din_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) din_q <= '0;
    else        din_q <= {din_q[sync_stages-2:0], din};
  end

  assign din_s = din_q[sync_stages-1];

  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [14:0]      shift_out;
  logic [15:0]      ctrl_shift;
  logic [2:0]       chan_ptr;
  logic [2:0]       ptr_next;
  logic [11:0]      sample_sel;
  logic [15:0]      frame_word;

  always_comb begin
    sample_sel = ch_data[11:0];
    for (int k = 1; k < 8; k++) begin
      if (chan_ptr == 3'(k)) sample_sel = ch_data[12*k +: 12];
    end
  end

  assign frame_word = {1'b0, chan_ptr, format_data(sample_sel, resolution, ctrl_reg[R_CODING])};

  always_comb begin
    ptr_next = chan_ptr;
    if (ctrl_shift[CTL_WRITE]) begin
      if (ctrl_shift[CTL_SEQ] && ctrl_shift[CTL_SHADOW]) ptr_next = 3'd0;
      else ptr_next = ctrl_shift[CTL_ADD_MSB:CTL_ADD_LSB];
    end else if (ctrl_reg[R_SEQ] && ctrl_reg[R_SHADOW]) begin
      ptr_next = (chan_ptr == ctrl_reg[R_ADD_MSB:R_ADD_LSB]) ? 3'd0 : chan_ptr + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_out   <= '0;
      ctrl_shift  <= '0;
      chan_ptr    <= 3'd0;
      ctrl_reg    <= '0;
      dout        <= 1'b0;
      dout_en     <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      if (cs_rise) begin
        state   <= IDLE;
        dout    <= 1'b0;
        dout_en <= 1'b0;
        if (bit_cnt == CNT_W'(FRAME_LEN)) begin
          frame_done <= 1'b1;
          chan_ptr   <= ptr_next;
          if (ctrl_shift[CTL_WRITE]) ctrl_reg <= ctrl_shift[15:CTL_REG_LSB];
        end else if (bit_cnt != '0) begin
          frame_error <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state     <= SHIFT;
              dout      <= frame_word[15];
              shift_out <= frame_word[14:0];
              dout_en   <= 1'b1;
              bit_cnt   <= '0;
            end
          end
          SHIFT: begin
            if (sclk_fall) begin
              ctrl_shift <= {ctrl_shift[14:0], din_s};
              dout       <= shift_out[14];
              shift_out  <= {shift_out[13:0], 1'b0};
              bit_cnt    <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
                state <= OVERRUN;
                dout  <= 1'b0;
              end
            end
          end
          OVERRUN: dout <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad79x8_responder.sv
// Randomized scoreboard bench for ad79x8_responder at resolutions 12, 10 and 8 sharing one
// SPI bus; a channel/control reference model predicts each frame's serial result.
module tb_ad79x8_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b1;
  logic        sclk = 1'b1;
  logic        din = 1'b0;
  logic [95:0] ch_data = '0;
  logic [2:0]  dout, dout_en, frame_done, frame_error;
  logic [11:0] ctrl_reg [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ad79x8_responder #(
      .resolution  ((g == 0) ? 12 : (g == 1) ? 10 : 8),
      .sync_stages (2)
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .cs          (cs),
      .sclk        (sclk),
      .din         (din),
      .dout        (dout[g]),
      .dout_en     (dout_en[g]),
      .ch_data     (ch_data),
      .ctrl_reg    (ctrl_reg[g]),
      .frame_done  (frame_done[g]),
      .frame_error (frame_error[g])
    );
  end

  typedef struct packed {
    logic [2:0][31:0] bits;
    logic [5:0]       nf;
    logic             done;
    logic             err;
    logic [11:0]      ctrl;
    logic             aborted;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [11:0] samp [8];
  int          sel = 0;
  logic [15:0] ctrl_w = '0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h", name, k, act, want);
    end
  endtask

  // Reference: the frame returns the channel chosen by the previous frame, then the
  // received word updates control/channel selection.
  function automatic void model_frame(input logic [15:0] word, input int nf, input bit aborted);
    exp_t e;
    int   res, d, frame;
    e = '0;
    e.nf = 6'(nf);
    e.aborted = aborted;
    for (int k = 0; k < 3; k++) begin
      res = (k == 0) ? 12 : (k == 1) ? 10 : 8;
      d = (int'(samp[sel]) >> (12 - res)) << (12 - res);
      if (ctrl_w[4]) d = d ^ 'h800;
      frame = sel * 4096 + d;
      e.bits[k] = 32'((nf <= 16) ? (frame >> (16 - nf)) : (frame << (nf - 16)));
    end
    if (!aborted) begin
      e.done = (nf >= 16);
      e.err  = (nf > 0 && nf < 16);
      if (e.done) begin
        if (word[15]) begin
          ctrl_w = word & 16'hFFF0;
          if (word[14] && word[7]) sel = 0;
          else sel = int'((word >> 10) & 16'h7);
        end else if (ctrl_w[14] && ctrl_w[7]) begin
          sel = (sel == int'((ctrl_w >> 10) & 16'h7)) ? 0 : sel + 1;
        end
      end
      e.ctrl = ctrl_w[15:4];
    end
    sb.push_back(e);
  endfunction

  task automatic load_samples();
    for (int k = 0; k < 8; k++) ch_data[12*k +: 12] = samp[k];
  endtask

  task automatic drive_bits(input logic [15:0] word, input int nf);
    int half;
    for (int i = 0; i < nf; i++) begin
      half = $urandom_range(4, 6);
      sclk = 1'b0;
      repeat (half) @(posedge clk);
      #1;
      sclk = 1'b1;
      din = (i < 15) ? word[14 - i] : 1'b0;
      repeat (half) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_frame(input logic [15:0] word, input int nf);
    load_samples();
    model_frame(word, nf, 1'b0);
    @(posedge clk);
    #1;
    cs = 1'b0;
    din = word[15];
    repeat (6) @(posedge clk);
    #1;
    drive_bits(word, nf);
    cs = 1'b1;
    din = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  // Monitor: collects dout at each sclk fall, counts pulses, checks 6 clk after cs rise.
  initial begin
    bit          prev_cs = 1'b1, prev_sclk = 1'b1;
    int          got_n = 0, chk_cnt = 0;
    logic [31:0] got_bits [3];
    int          n_done [3], n_err [3], en_bad [3];
    exp_t        e;
    for (int k = 0; k < 3; k++) begin
      got_bits[k] = '0; n_done[k] = 0; n_err[k] = 0; en_bad[k] = 0;
    end
    forever begin
      @(negedge clk);
      if (prev_cs && !cs) begin
        got_n = 0;
        for (int k = 0; k < 3; k++) begin
          got_bits[k] = '0; n_done[k] = 0; n_err[k] = 0; en_bad[k] = 0;
        end
      end
      if (!cs && prev_sclk && !sclk) begin
        got_n++;
        for (int k = 0; k < 3; k++) begin
          got_bits[k] = {got_bits[k][30:0], dout[k]};
          if (!dout_en[k]) en_bad[k]++;
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_done[k] += int'(frame_done[k]);
        n_err[k]  += int'(frame_error[k]);
      end
      if (!prev_cs && cs) chk_cnt = 6;
      else if (chk_cnt > 0) begin
        chk_cnt--;
        if (chk_cnt == 0) begin
          if (sb.size() == 0) chk("sb_nonempty", 0, 32'd0, 32'd1);
          else begin
            e = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
              if (!e.aborted) begin
                chk("nbits", k, 32'(got_n), 32'(e.nf));
                chk("dout_stream", k, got_bits[k], e.bits[k]);
                chk("dout_en_in_frame", k, 32'(en_bad[k]), 32'd0);
              end
              chk("frame_done_cnt", k, 32'(n_done[k]), 32'(e.done));
              chk("frame_error_cnt", k, 32'(n_err[k]), 32'(e.err));
              chk("ctrl_reg", k, 32'(ctrl_reg[k]), 32'(e.ctrl));
              chk("dout_en_idle", k, 32'(dout_en[k]), 32'd0);
              chk("dout_idle", k, 32'(dout[k]), 32'd0);
            end
          end
        end
      end
      prev_cs = cs;
      prev_sclk = sclk;
    end
  end

  initial begin
    #(5_000_000);
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w;
    int          pick, nf;
    for (int k = 0; k < 8; k++) samp[k] = 12'(k * 'h111);
    load_samples();
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_dout", k, 32'(dout[k]), 32'd0);
      chk("rst_dout_en", k, 32'(dout_en[k]), 32'd0);
      chk("rst_ctrl_reg", k, 32'(ctrl_reg[k]), 32'd0);
      chk("rst_pulses", k, 32'({frame_done[k], frame_error[k]}), 32'd0);
    end
    reset = 1'b1;
    repeat (5) @(posedge clk);

    samp[0] = 12'hABC;
    do_frame(16'h0000, 16);
    do_frame(16'h8C00, 16);
    samp[3] = 12'h123;
    do_frame(16'h0000, 16);
    do_frame(16'hC880, 16);
    repeat (4) do_frame(16'h0000, 16);
    samp[0] = 12'hFFF;
    do_frame(16'h8010, 16);
    do_frame(16'h0000, 16);
    do_frame(16'h8400, 16);
    do_frame(16'hFFFF, 7);
    do_frame(16'h0000, 16);
    do_frame(16'h0000, 20);
    do_frame(16'h0000, 0);

    // mid-frame reset: all samples 0xFFF so bit 5 of the frame is a 1 before reset hits
    for (int k = 0; k < 8; k++) samp[k] = 12'hFFF;
    load_samples();
    model_frame(16'h0000, 5, 1'b1);
    @(posedge clk);
    #1;
    cs = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    drive_bits(16'h0000, 5);
    for (int k = 0; k < 3; k++) begin
      chk("pre_reset_dout", k, 32'(dout[k]), 32'd1);
      chk("pre_reset_dout_en", k, 32'(dout_en[k]), 32'd1);
    end
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("async_reset_dout", k, 32'(dout[k]), 32'd0);
      chk("async_reset_dout_en", k, 32'(dout_en[k]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    cs = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    sel = 0;
    ctrl_w = '0;
    repeat (4) @(posedge clk);
    samp[0] = 12'h5A5;
    do_frame(16'h0000, 16);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 8; k++) samp[k] = 12'($urandom);
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w = w | 16'hC080;
      pick = $urandom_range(0, 9);
      nf = (pick < 6) ? 16 : (pick == 6) ? 20 : (pick == 7) ? 0 : $urandom_range(1, 15);
      do_frame(w, nf);
    end

    repeat (20) @(posedge clk);
    chk("sb_drained", 0, 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
